// File: rtl/bitty_uart_pkg.sv
// Shared framing definitions for the bitty result UART path.
package bitty_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bitty_result_fifo.sv
// Small synchronous FIFO holding captured result words until the serialiser takes them.
module bitty_result_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bitty_result_uart_tx.sv
// Captures bitty core results on done and streams them out as two 8N1 frames, low byte first.
module bitty_result_uart_tx
    import bitty_uart_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done,
    input  logic [DATA_W-1:0]           d_out,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t                 state;
    logic [CNT_W-1:0]          baud_cnt;
    logic [2:0]                bit_idx;
    logic                      byte_sel;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [DATA_W-1:0]         hold_word;
    logic [UART_DATA_BITS-1:0] next_byte;
    logic [DATA_W-1:0]         fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      baud_wrap;
    logic                      stop_done;

    assign baud_wrap = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_done = baud_wrap && (bit_idx == 3'(UART_STOP_BITS - 1));
    assign next_byte = byte_sel ? hold_word[DATA_W-1 -: UART_DATA_BITS]
                                : hold_word[UART_DATA_BITS-1:0];
    // Pops happen from idle, or at the end of a word's last stop bit for back-to-back words.
    assign fifo_pop  = !fifo_empty &&
                       ((state == IDLE) || (state == STOP && stop_done && byte_sel));
    assign busy      = (state != IDLE) || (fifo_count != '0);

    bitty_result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (done),
        .pop   (fifo_pop),
        .wdata (d_out),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_sel  <= 1'b0;
            shift_reg <= '0;
            hold_word <= '0;
            tx        <= UART_IDLE_LEVEL;
            overflow  <= 1'b0;
        end else begin
            if (done && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= UART_IDLE_LEVEL;
                    if (!fifo_empty) begin
                        hold_word <= fifo_rdata;
                        shift_reg <= fifo_rdata[UART_DATA_BITS-1:0];
                        byte_sel  <= 1'b0;
                        bit_idx   <= '0;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        shift_reg <= next_byte;
                        tx        <= next_byte[0];
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            tx      <= UART_IDLE_LEVEL;
                            state   <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (!stop_done) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            bit_idx <= '0;
                            if (!byte_sel) begin
                                shift_reg <= hold_word[DATA_W-1 -: UART_DATA_BITS];
                                byte_sel  <= 1'b1;
                                tx        <= 1'b0;
                                state     <= START;
                            end else if (!fifo_empty) begin
                                hold_word <= fifo_rdata;
                                shift_reg <= fifo_rdata[UART_DATA_BITS-1:0];
                                byte_sel  <= 1'b0;
                                tx        <= 1'b0;
                                state     <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_result_uart_tx.sv
// Directed bench for bitty_result_uart_tx: decodes tx frames and checks FIFO/overflow corners.
module tb_bitty_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [15:0] d_out;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    vec_t vecs[6];

    bitty_result_uart_tx #(
        .DATA_W       (16),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .done       (done),
        .d_out      (d_out),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Strobe done for one cycle; called and returns at a falling edge.
    task automatic applyStimulus(input logic [15:0] word);
        done  = 1'b1;
        d_out = word;
        @(negedge clk);
        done  = 1'b0;
    endtask

    // Decode one 8N1 frame; returns at offset 39 of the frame (last stop-bit cycle).
    task automatic receive_byte(input string tag, output logic [7:0] b, output int gap);
        gap = 0;
        b   = 8'h00;
        while (tx !== 1'b0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        if (tx !== 1'b0) begin
            checkOutput({tag, "_start_timeout"}, 32'(tx), 32'h0);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        checkOutput({tag, "_start_bit"}, 32'(tx), 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        checkOutput({tag, "_stop_bit"}, 32'(tx), 32'h1);
        repeat (CPB / 2 - 1) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx_b;
        int         gap;
        int         bad;
        logic [7:0] exp_b2b [6];

        vecs[0] = '{word: 16'hA55A, lo: 8'h5A, hi: 8'hA5};
        vecs[1] = '{word: 16'hFFFF, lo: 8'hFF, hi: 8'hFF};
        vecs[2] = '{word: 16'h0000, lo: 8'h00, hi: 8'h00};
        vecs[3] = '{word: 16'h8001, lo: 8'h01, hi: 8'h80};
        vecs[4] = '{word: 16'hC3E7, lo: 8'hE7, hi: 8'hC3};
        vecs[5] = '{word: 16'h1E2D, lo: 8'h2D, hi: 8'h1E};
        exp_b2b = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'h01, 8'h00};

        reset = 1'b1;
        done  = 1'b0;
        d_out = 16'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'h1);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        checkOutput("reset_count", 32'(fifo_count), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single words: latency, both bytes, no inter-byte gap, busy drop after 80 cycles
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].word);
            checkOutput("single_tx_after_push", 32'(tx), 32'h1);
            checkOutput("single_count_after_push", 32'(fifo_count), 32'h1);
            receive_byte("single_lo", rx_b, gap);
            checkOutput("single_latency", 32'(gap), 32'h1);
            checkOutput("single_lo_byte", 32'(rx_b), 32'(vecs[v].lo));
            receive_byte("single_hi", rx_b, gap);
            checkOutput("single_byte_gap", 32'(gap), 32'h1);
            checkOutput("single_hi_byte", 32'(rx_b), 32'(vecs[v].hi));
            checkOutput("single_busy_last_cycle", 32'(busy), 32'h1);
            @(negedge clk);
            checkOutput("single_busy_drop", 32'(busy), 32'h0);
            checkOutput("single_tx_idle", 32'(tx), 32'h1);
        end

        // Back-to-back words on consecutive cycles
        fork
            begin
                done  = 1'b1;
                d_out = 16'h1234;
                @(negedge clk);
                checkOutput("b2b_count_0", 32'(fifo_count), 32'h1);
                d_out = 16'hBEEF;
                @(negedge clk);
                checkOutput("b2b_count_1", 32'(fifo_count), 32'h1);
                d_out = 16'h0001;
                @(negedge clk);
                checkOutput("b2b_count_peak", 32'(fifo_count), 32'h2);
                done = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    receive_byte("b2b", rx_b, gap);
                    checkOutput("b2b_byte", 32'(rx_b), 32'(exp_b2b[k]));
                    checkOutput("b2b_gap", 32'(gap), (k == 0) ? 32'h2 : 32'h1);
                end
            end
        join
        checkOutput("b2b_busy_cycle_239", 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput("b2b_busy_cycle_240", 32'(busy), 32'h0);

        // Overflow: six strobes into a four-deep FIFO during the first frame
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    done  = 1'b1;
                    d_out = 16'(k);
                    @(negedge clk);
                end
                done = 1'b0;
                checkOutput("ovf_flag_set", 32'(overflow), 32'h1);
                checkOutput("ovf_count_full", 32'(fifo_count), 32'h4);
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    receive_byte("ovf", rx_b, gap);
                    checkOutput("ovf_byte", 32'(rx_b), (k % 2 == 0) ? 32'(k / 2) : 32'h0);
                    checkOutput("ovf_gap", 32'(gap), (k == 0) ? 32'h2 : 32'h1);
                end
            end
        join
        @(negedge clk);
        checkOutput("ovf_drained_busy", 32'(busy), 32'h0);
        checkOutput("ovf_drained_count", 32'(fifo_count), 32'h0);
        checkOutput("ovf_sticky", 32'(overflow), 32'h1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("ovf_cleared_by_reset", 32'(overflow), 32'h0);

        // Push while full on the edge that pops the next word
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    done  = 1'b1;
                    d_out = 16'h0100 + 16'(k);
                    @(negedge clk);
                end
                done = 1'b0;
                checkOutput("pp_count_full", 32'(fifo_count), 32'h4);
                repeat (76) @(negedge clk);
                checkOutput("pp_count_before_pop", 32'(fifo_count), 32'h4);
                done  = 1'b1;
                d_out = 16'h0105;
                @(negedge clk);
                done = 1'b0;
                checkOutput("pp_count_unchanged", 32'(fifo_count), 32'h4);
                checkOutput("pp_no_overflow", 32'(overflow), 32'h0);
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    receive_byte("pp", rx_b, gap);
                    checkOutput("pp_byte", 32'(rx_b), (k % 2 == 0) ? 32'(k / 2) : 32'h1);
                    checkOutput("pp_gap", 32'(gap), (k == 0) ? 32'h2 : 32'h1);
                end
            end
        join
        @(negedge clk);
        checkOutput("pp_drained_busy", 32'(busy), 32'h0);
        checkOutput("pp_final_overflow", 32'(overflow), 32'h0);

        // Reset during data bit 3 of the high byte, with a second word still queued
        done  = 1'b1;
        d_out = 16'hA55A;
        @(negedge clk);
        d_out = 16'h1111;
        @(negedge clk);
        done = 1'b0;
        repeat (57) @(negedge clk);
        checkOutput("rst_mid_tx_bit3", 32'(tx), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h1);
        checkOutput("rst_mid_count", 32'(fifo_count), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_tx", 32'(tx), 32'h1);
        checkOutput("rst_mid_busy_clr", 32'(busy), 32'h0);
        checkOutput("rst_mid_count_clr", 32'(fifo_count), 32'h0);
        checkOutput("rst_mid_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        applyStimulus(16'h3C5A);
        receive_byte("rst_after_lo", rx_b, gap);
        checkOutput("rst_after_latency", 32'(gap), 32'h1);
        checkOutput("rst_after_lo_byte", 32'(rx_b), 32'h5A);
        receive_byte("rst_after_hi", rx_b, gap);
        checkOutput("rst_after_hi_byte", 32'(rx_b), 32'h3C);
        @(negedge clk);
        checkOutput("rst_after_idle", 32'(busy), 32'h0);

        // Idle line for 1000 cycles after reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checkOutput("idle_line_quiet", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
